// File: rtl/inst_prefetch_pkg.sv
// inst_prefetch_pkg: shared types and default widths for the instruction prefetch queue.
`default_nettype none

package inst_prefetch_pkg;

  localparam int PC_W_DEF   = 8;
  localparam int INST_W_DEF = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STOP = 2'd2
  } state_t;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
  } entry_t;

endpackage

`default_nettype wire

// File: rtl/inst_fifo.sv
// inst_fifo: DEPTH-entry circular queue with push/pop/flush and occupancy output.
`default_nettype none

module inst_fifo
  import inst_prefetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = entry_t
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  T               mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

`default_nettype wire

// File: rtl/inst_prefetch.sv
// inst_prefetch: credit-based instruction fetch into a small queue with redirect/halt.
// Optional PREFETCH_STATS_EN adds saturating fetch_count/flush_count outputs.
`default_nettype none

module inst_prefetch
  import inst_prefetch_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PC_W   = PC_W_DEF,
  parameter int INST_W = INST_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              rom_req,
  output logic [PC_W-1:0]   rom_addr,
  input  logic [INST_W-1:0] rom_data,
  output logic [INST_W-1:0] inst_out,
  output logic [PC_W-1:0]   inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt,
  output logic              halted
`ifdef PREFETCH_STATS_EN
  ,
  output logic [15:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } qentry_t;

  state_t           state, next_state;
  logic [PC_W-1:0]  pc;
  logic             inflight_v;
  logic [PC_W-1:0]  inflight_pc;
  logic [CW-1:0]    occ;
  qentry_t          head;
  qentry_t          push_entry;
  logic             flush, push, pop_req, credit_ok;

  assign flush     = start | redirect;
  // Redirect/start kill the response arriving this cycle.
  assign push      = inflight_v & ~flush;
  assign pop_req   = inst_valid & inst_ready;
  assign credit_ok = (int'(occ) + int'(inflight_v)) < DEPTH;
  assign push_entry = '{pc: inflight_pc, inst: rom_data};

  always_comb begin
    next_state = state;
    rom_req    = 1'b0;
    case (state)
      S_IDLE: if (!start) next_state = S_RUN;
      S_RUN: begin
        if (start)     next_state = S_IDLE;
        else if (halt) next_state = S_STOP;
        else           rom_req    = credit_ok & ~redirect;
      end
      S_STOP: if (start) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else begin
      state       <= next_state;
      inflight_v  <= rom_req;
      inflight_pc <= pc;
      if (start)         pc <= '0;
      else if (redirect) pc <= redirect_pc;
      else if (rom_req)  pc <= pc + 1'b1;
    end
  end

  inst_fifo #(
    .DEPTH (DEPTH),
    .T     (qentry_t)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop_req),
    .flush     (flush),
    .head      (head),
    .count     (occ)
  );

  assign rom_addr   = pc;
  assign inst_valid = (occ != '0);
  assign inst_out   = inst_valid ? head.inst : '0;
  assign inst_pc    = inst_valid ? head.pc : '0;
  assign halted     = (state == S_STOP);

`ifdef PREFETCH_STATS_EN
  logic [16:0] killed;
  logic [16:0] flush_sum;

  always_comb begin
    killed = '0;
    if (flush) killed = 17'(occ) - 17'(pop_req) + 17'(inflight_v);
    flush_sum = {1'b0, flush_count} + killed;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else if (start) begin
      fetch_count <= '0;
      flush_count <= '0;
    end else begin
      if (push && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
      flush_count <= flush_sum[16] ? 16'hFFFF : flush_sum[15:0];
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch.sv
// tb_inst_prefetch: directed self-checking bench for inst_prefetch (DEPTH=4, PC_W=8, INST_W=9).
`default_nettype none

module tb_inst_prefetch;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic       rom_req;
  logic [7:0] rom_addr;
  logic [8:0] rom_data = 9'h0;
  logic [8:0] inst_out;
  logic [7:0] inst_pc;
  logic       inst_valid;
  logic       inst_ready;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       halt;
  logic       halted;

  int n_cmp = 0;
  int n_err = 0;
  int req_count = 0;
  int r0;

  inst_prefetch dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .inst_out    (inst_out),
    .inst_pc     (inst_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  // ROM model: word = 0x100 + address, valid the cycle after the strobe.
  always @(posedge clk) begin
    rom_data <= rom_req ? {1'b1, rom_addr} : 9'h0;
    if (rom_req === 1'b1) req_count <= req_count + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Wait (bounded) for the next accepted head, check it, then step past the pop.
  task automatic expect_pop(input string tag, input logic [7:0] pc);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (inst_valid === 1'b1) begin
        chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
        chk({tag, "_inst"}, 32'(inst_out), 32'h100 | 32'(pc));
        got = 1'b1;
      end
      cyc();
      #1;
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed no delivery expected pc %0h", tag, pc);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b1; inst_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 8'h0; halt = 1'b0;
    #3;
    chk("rst_rom_req", 32'(rom_req), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_inst_out", 32'(inst_out), 0);
    chk("rst_inst_pc", 32'(inst_pc), 0);
    chk("rst_halted", 32'(halted), 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc(); cyc();

    // Streaming with ready high: valid two cycles after first strobe.
    cyc(); start = 1'b0; inst_ready = 1'b1; #1;
    chk("a_idle_req", 32'(rom_req), 0);
    cyc(); #1;
    chk("a_req0", 32'(rom_req), 1);
    chk("a_addr0", 32'(rom_addr), 0);
    chk("a_valid_c1", 32'(inst_valid), 0);
    cyc(); #1;
    chk("a_addr1", 32'(rom_addr), 1);
    chk("a_valid_c2", 32'(inst_valid), 0);
    cyc(); #1;
    chk("a_valid_c3", 32'(inst_valid), 1);
    chk("a_pc0", 32'(inst_pc), 0);
    chk("a_inst0", 32'(inst_out), 32'h100);
    cyc(); #1;
    chk("a_pc1", 32'(inst_pc), 1);
    chk("a_inst1", 32'(inst_out), 32'h101);
    cyc(); #1;
    chk("a_pc2", 32'(inst_pc), 2);

    // Backpressure: exactly DEPTH strobes, then in-order drain.
    start = 1'b1; inst_ready = 1'b0;
    cyc(); start = 1'b0; #1;
    chk("b_flushed", 32'(inst_valid), 0);
    r0 = req_count;
    repeat (12) cyc();
    #1;
    chk("b_req_count", 32'(req_count - r0), 4);
    chk("b_req_stopped", 32'(rom_req), 0);
    chk("b_head_pc", 32'(inst_pc), 0);
    inst_ready = 1'b1;
    expect_pop("b_pop0", 8'h00);
    expect_pop("b_pop1", 8'h01);
    expect_pop("b_pop2", 8'h02);
    expect_pop("b_pop3", 8'h03);

    // Redirect with three queued and one in flight.
    start = 1'b1; inst_ready = 1'b0;
    cyc(); start = 1'b0;
    repeat (5) cyc();
    redirect = 1'b1; redirect_pc = 8'h40; #1;
    chk("c_req_blocked", 32'(rom_req), 0);
    chk("c_head_pc", 32'(inst_pc), 0);
    cyc(); redirect = 1'b0; #1;
    chk("c_valid_low", 32'(inst_valid), 0);
    chk("c_req_tgt", 32'(rom_req), 1);
    chk("c_addr_tgt", 32'(rom_addr), 32'h40);
    cyc(); #1;
    chk("c_valid_low2", 32'(inst_valid), 0);
    chk("c_addr_tgt1", 32'(rom_addr), 32'h41);
    cyc(); #1;
    chk("c_valid_tgt", 32'(inst_valid), 1);
    chk("c_pc_tgt", 32'(inst_pc), 32'h40);
    chk("c_inst_tgt", 32'(inst_out), 32'h140);

    // PC wrap 0xFF -> 0x00.
    inst_ready = 1'b1; redirect = 1'b1; redirect_pc = 8'hFE;
    cyc(); redirect = 1'b0; #1;
    chk("d_addr_fe", 32'(rom_addr), 32'hFE);
    chk("d_valid_low", 32'(inst_valid), 0);
    expect_pop("d_pop_fe", 8'hFE);
    expect_pop("d_pop_ff", 8'hFF);
    expect_pop("d_pop_00", 8'h00);
    expect_pop("d_pop_01", 8'h01);

    // Halt at PC=5 with entries 3 and 4 still to deliver.
    inst_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h03;
    cyc(); redirect = 1'b0; #1;
    chk("e_addr3", 32'(rom_addr), 3);
    cyc(); #1;
    chk("e_addr4", 32'(rom_addr), 4);
    cyc(); halt = 1'b1; #1;
    chk("e_halt_noreq", 32'(rom_req), 0);
    chk("e_head3", 32'(inst_pc), 3);
    r0 = req_count;
    cyc(); halt = 1'b0; #1;
    chk("e_halted", 32'(halted), 1);
    inst_ready = 1'b1;
    expect_pop("e_pop3", 8'h03);
    expect_pop("e_pop4", 8'h04);
    repeat (4) cyc();
    #1;
    chk("e_empty", 32'(inst_valid), 0);
    chk("e_halted_hold", 32'(halted), 1);
    chk("e_no_req", 32'(req_count - r0), 0);
    start = 1'b1;
    cyc(); start = 1'b0; #1;
    chk("e_unhalted", 32'(halted), 0);
    chk("e_idle_req", 32'(rom_req), 0);
    cyc(); #1;
    chk("e_restart_req", 32'(rom_req), 1);
    chk("e_restart_addr", 32'(rom_addr), 0);

    // Asynchronous reset with a response in flight.
    cyc(); cyc(); #1;
    start = 1'b1;
    reset_n = 1'b0; #1;
    chk("f_rom_req", 32'(rom_req), 0);
    chk("f_rom_addr", 32'(rom_addr), 0);
    chk("f_valid", 32'(inst_valid), 0);
    chk("f_inst_out", 32'(inst_out), 0);
    chk("f_inst_pc", 32'(inst_pc), 0);
    chk("f_halted", 32'(halted), 0);
    #2 reset_n = 1'b1;
    cyc(); #1;
    chk("f_no_push1", 32'(inst_valid), 0);
    cyc(); #1;
    chk("f_no_push2", 32'(inst_valid), 0);
    chk("f_no_req", 32'(rom_req), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/inst_prefetch.md
INST_PREFETCH -- requirements
Module: inst_prefetch

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, 2..16).
REQ-002 The module SHALL have parameter PC_W, default 8, meaning instruction address width.
REQ-003 The module SHALL have parameter INST_W, default 9, meaning instruction width.
REQ-004 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-005 RESET_N  input  1  reset, asynchronous, active-low.
REQ-006 START  input  1  synchronous init: flush, PC=0, hold idle while high.
REQ-007 ROM_REQ  output  1  instruction-ROM read strobe.
REQ-008 ROM_ADDR  output  PC_W  address for ROM_REQ.
REQ-009 ROM_DATA  input  INST_W  ROM word, valid exactly one cycle after ROM_REQ.
REQ-010 INST_OUT  output  INST_W  head-of-queue instruction to decode.
REQ-011 INST_PC  output  PC_W  address of INST_OUT.
REQ-012 INST_VALID  output  1  INST_OUT/INST_PC valid.
REQ-013 INST_READY  input  1  decode accepts the head this cycle.
REQ-014 REDIRECT  input  1  taken branch; restart fetch at REDIRECT_PC.
REQ-015 REDIRECT_PC  input  PC_W  branch target.
REQ-016 HALT  input  1  decoded halt; stop fetching.
REQ-017 HALTED  output  1  fetch stopped by HALT.

Function
REQ-018 The fetch FSM SHALL have states IDLE, RUN, STOP; IDLE->RUN when START low; RUN->STOP on HALT; any state->IDLE while START high.
REQ-019 In RUN the block SHALL assert ROM_REQ with ROM_ADDR=PC when queue occupancy plus in-flight requests < DEPTH, then increment PC modulo 2^PC_W (255 wraps to 0).
REQ-020 A ROM response SHALL be pushed at the edge ending its valid cycle, tagged with its address; INST_VALID rises the following cycle (ROM_REQ at t -> INST_VALID at t+2 with empty queue).
REQ-021 A pop SHALL occur on edges where INST_VALID and INST_READY are both high; simultaneous push and pop SHALL leave occupancy unchanged.
REQ-022 The queue SHALL never overflow; credit rule REQ-019 guarantees it, and INST_VALID is low exactly when empty.
REQ-023 On REDIRECT the block SHALL flush the queue, mark any in-flight response dead (not pushed), set PC=REDIRECT_PC, and issue the first ROM_REQ at REDIRECT_PC the next cycle.
REQ-024 REDIRECT with INST_READY in the same cycle SHALL count the head as consumed; REDIRECT takes priority over push.
REQ-025 In STOP no ROM_REQ SHALL issue; queued and in-flight entries remain deliverable; HALTED=1.
REQ-026 HALT and REDIRECT in the same cycle SHALL flush and enter STOP.
REQ-027 START high SHALL flush queue, kill in-flight, set PC=0, clear HALTED.

Reset
REQ-028 RESET_N low SHALL immediately force state IDLE, PC=0, queue empty, no in-flight, ROM_REQ=0, ROM_ADDR=0, INST_VALID=0, INST_OUT=0, INST_PC=0, HALTED=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; responses arriving after deassertion SHALL be ignored.

Configuration
REQ-030 With PREFETCH_STATS_EN defined, outputs FETCH_COUNT and FLUSH_COUNT (16 bits, saturating, reset 0, cleared by START) SHALL count pushes and flushed/killed entries.
REQ-031 Without PREFETCH_STATS_EN those ports and counters SHALL not exist; behaviour otherwise identical.

Structure
REQ-032 Package inst_prefetch_pkg SHALL hold the FSM state enum, default PC_W/INST_W constants, and the queue-entry struct {pc, inst}.
REQ-033 Queue storage and pointers SHALL be sub-module inst_fifo (DEPTH entries, push/pop/flush, occupancy out).

Verification
REQ-034 Reset then START low, ROM returns addr+0x100, INST_READY=1 -> INST_VALID first 2 cycles after first ROM_REQ, INST_PC 0,1,2,... each cycle.
REQ-035 INST_READY=0 for 10 cycles, DEPTH=4 -> ROM_REQ stops after 4 outstanding, no entry lost; release -> PCs 0..3 delivered in order.
REQ-036 REDIRECT to 0x40 with 3 queued and 1 in flight -> INST_VALID low next cycle, next delivered INST_PC=0x40, no stale word appears.
REQ-037 Start at PC=0xFE, ready high -> INST_PC sequence FE, FF, 00, 01.
REQ-038 HALT at PC=0x05 with 2 queued -> no further ROM_REQ, both entries delivered, HALTED=1; START pulse -> restart at PC=0.
REQ-039 RESET_N low mid-stream with response in flight -> all outputs zero immediately, no push after release.
